// File: rtl/cpu_core_p.sv
// cpu_core_p: single-cycle register-file CPU with zero/carry flags, branches and a blocking input
// handshake. Define CPU_STACK_EN to build the optional hardware call/return stack.
module cpu_core_p #(
    parameter int DATA_W      = 8,
    parameter int IP_W        = 8,
    parameter int NUM_REGS    = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [31:0]       instruction,
    output logic [IP_W-1:0]   instruction_pointer,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ack,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [1:0]        flags,
    output logic              halted,
    output logic              stack_err
);

    localparam int RW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        G_NOP, G_ALU, G_LDI, G_BR, G_CALL, G_RET, G_IN, G_OUT
    } group_e;

    typedef enum logic [2:0] {
        ALU_MOV, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_NOT
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_JMP, BR_JZ, BR_JNZ, BR_JC, BR_HALT, BR_NOP5, BR_NOP6, BR_NOP7
    } br_op_e;

    group_e            grp;
    alu_op_e           alu_op;
    br_op_e            br_op;
    logic [RW-1:0]     rd_idx;
    logic [RW-1:0]     rs_idx;
    logic [DATA_W-1:0] imm;
    logic [IP_W-1:0]   target;
    logic              unused_bits;

    assign grp         = group_e'(instruction[31:29]);
    assign alu_op      = alu_op_e'(instruction[28:26]);
    assign br_op       = br_op_e'(instruction[28:26]);
    assign rs_idx      = instruction[16 +: RW];
    assign rd_idx      = instruction[8 +: RW];
    assign imm         = DATA_W'(instruction[23:16]);
    assign target      = IP_W'(instruction[7:0]);
    assign unused_bits = ^instruction;

    logic [IP_W-1:0]   ip;
    logic [IP_W-1:0]   ip_inc;
    logic [IP_W-1:0]   ip_next;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W:0]   alu_wide;
    logic              reg_we;
    logic              zero, carry, zero_next, carry_next;
    logic              out_we, halt_set, step;

    assign ip_inc = ip + IP_W'(1);
    assign rd_val = regs[rd_idx];
    assign rs_val = regs[rs_idx];
    assign step   = enable && !halted;

`ifdef CPU_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    logic [IP_W-1:0] stack_mem [STACK_DEPTH];
    logic [SPW-1:0]  sp;
    logic [SPW-2:0]  top_idx;
    logic            push, pop, err_set, stack_err_q;

    assign top_idx = (SPW-1)'(sp - 1'b1);
`endif

    // NOTE: always_comb uses blocking assignments and gives every output a default first, so no latch is inferred.
    always_comb begin
        ip_next    = ip_inc;
        reg_we     = 1'b0;
        reg_wdata  = rd_val;
        alu_wide   = '0;
        zero_next  = zero;
        carry_next = carry;
        out_we     = 1'b0;
        halt_set   = 1'b0;
`ifdef CPU_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
`endif
        case (grp)
            G_ALU: begin
                case (alu_op)
                    ALU_MOV: alu_wide = {1'b0, rs_val};
                    ALU_ADD: alu_wide = {1'b0, rd_val} + {1'b0, rs_val};
                    ALU_SUB: alu_wide = {1'b0, rd_val} - {1'b0, rs_val};
                    ALU_AND: alu_wide = {1'b0, rd_val & rs_val};
                    ALU_OR:  alu_wide = {1'b0, rd_val | rs_val};
                    ALU_XOR: alu_wide = {1'b0, rd_val ^ rs_val};
                    ALU_INC: alu_wide = {1'b0, rd_val} + (DATA_W+1)'(1);
                    default: alu_wide = {1'b0, ~rd_val};
                endcase
                reg_we    = 1'b1;
                reg_wdata = alu_wide[DATA_W-1:0];
                if (alu_op != ALU_MOV)
                    zero_next = (alu_wide[DATA_W-1:0] == '0);
                // Bit DATA_W is carry-out for the additions and borrow for SUB.
                if (alu_op == ALU_ADD || alu_op == ALU_SUB || alu_op == ALU_INC)
                    carry_next = alu_wide[DATA_W];
            end
            G_LDI: begin
                reg_we    = 1'b1;
                reg_wdata = imm;
            end
            G_BR: begin
                case (br_op)
                    BR_JMP:  ip_next = target;
                    BR_JZ:   if (zero)  ip_next = target;
                    BR_JNZ:  if (!zero) ip_next = target;
                    BR_JC:   if (carry) ip_next = target;
                    BR_HALT: begin
                        halt_set = 1'b1;
                        ip_next  = ip;
                    end
                    default: ;
                endcase
            end
`ifdef CPU_STACK_EN
            G_CALL: begin
                if (sp == SPW'(STACK_DEPTH)) begin
                    err_set  = 1'b1;
                    halt_set = 1'b1;
                    ip_next  = ip;
                end else begin
                    push    = 1'b1;
                    ip_next = target;
                end
            end
            G_RET: begin
                if (sp == '0) begin
                    err_set  = 1'b1;
                    halt_set = 1'b1;
                    ip_next  = ip;
                end else begin
                    pop     = 1'b1;
                    ip_next = stack_mem[top_idx];
                end
            end
`endif
            G_IN: begin
                if (din_valid) begin
                    reg_we    = 1'b1;
                    reg_wdata = din;
                end else begin
                    ip_next = ip;
                end
            end
            G_OUT: out_we = 1'b1;
            default: ;
        endcase
    end

    // Gated by resetn so the ack reads 0 while reset is held, even on an IN at address 0.
    assign din_ack = resetn && step && (grp == G_IN) && din_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the register file is reset because programs may read a register before writing it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ip         <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            halted     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            dout_valid <= step && out_we;
            if (step) begin
                ip    <= ip_next;
                zero  <= zero_next;
                carry <= carry_next;
                if (reg_we)
                    regs[rd_idx] <= reg_wdata;
                if (out_we)
                    dout <= rs_val;
                if (halt_set)
                    halted <= 1'b1;
            end
        end
    end

`ifdef CPU_STACK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sp          <= '0;
            stack_err_q <= 1'b0;
        end else if (step) begin
            if (push)
                sp <= sp + 1'b1;
            if (pop)
                sp <= sp - 1'b1;
            if (err_set)
                stack_err_q <= 1'b1;
        end
    end

    // Storage is deliberately unreset: sp alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (step && push)
            stack_mem[(SPW-1)'(sp)] <= ip_inc;
    end

    assign stack_err = stack_err_q;
`else
    localparam int unused_stack_depth = STACK_DEPTH;
    assign stack_err = 1'b0;
`endif

    assign instruction_pointer = ip;
    assign flags               = {carry, zero};

endmodule
